// File: rtl/shift_add_pipe.sv
// shift_add_pipe: multi-lane pipelined constant-coefficient multiplier.
// Each lane's weight is split at elaboration into up to DEPTH signed
// power-of-two terms, and one term is applied per pipeline stage. An output
// stage rescales by NFRAC bits and saturates back to BITS. A weight that is
// not exactly representable in DEPTH terms uses a true multiply in stage 1.
// Flow control is a global stall: every stage advances only when the output
// register is empty or being drained.
// Optional build macro SHIFT_ADD_ROUND_EN: round half up before rescaling
// (otherwise the rescale truncates toward -inf).
module shift_add_pipe #(
   parameter int NCH   = 4,
   parameter int BITS  = 17,
   parameter int NFRAC = 8,
   parameter int DEPTH = 3,
   parameter logic [NCH*BITS-1:0] WEIGHTS = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NCH*BITS-1:0] data_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NCH*BITS-1:0] data_out
);

   localparam int AW = 2 * BITS;

   // Nearest power of two to a positive value; exact ties round upward so
   // that e.g. 384 becomes +512 -128.
   function automatic longint nearest_pow2(longint a);
      longint p = 1;
      for (int b = 0; b < 62; b++) begin
         if ((p << 1) <= a) p = p << 1;
      end
      if ((a - p) >= ((p << 1) - a)) p = p << 1;
      return p;
   endfunction

   // Next greedy signed term for a remainder (0 once the remainder is 0).
   function automatic longint next_term(longint rem);
      if (rem == 0) return 0;
      else if (rem > 0) return nearest_pow2(rem);
      else return -nearest_pow2(-rem);
   endfunction

   // Term number idx of the greedy decomposition of w.
   function automatic longint term_val(longint w, int idx);
      longint rem = w;
      longint t = 0;
      for (int j = 0; j <= idx; j++) begin
         t   = next_term(rem);
         rem = rem - t;
      end
      return t;
   endfunction

   // A weight is complex when DEPTH greedy terms leave a nonzero remainder.
   function automatic bit is_complex(longint w);
      longint rem = w;
      for (int j = 0; j < DEPTH; j++) begin
         rem = rem - next_term(rem);
      end
      return rem != 0;
   endfunction

   // Shift amount of an exact power of two.
   function automatic int log2_exact(longint v);
      int r = 0;
      for (int b = 0; b < 62; b++) begin
         if ((longint'(1) << b) == v) r = b;
      end
      return r;
   endfunction

   localparam logic signed [AW-1:0] SAT_MAX = AW'((longint'(1) <<< (BITS-1)) - 1);
   localparam logic signed [AW-1:0] SAT_MIN = AW'(-(longint'(1) <<< (BITS-1)));
`ifdef SHIFT_ADD_ROUND_EN
   localparam logic signed [AW-1:0] RND_HALF =
      (NFRAC > 0) ? AW'(longint'(1) <<< ((NFRAC > 0) ? NFRAC - 1 : 0)) : '0;
`endif

   logic                   adv;
   logic                   stage_vld [DEPTH];
   logic signed [BITS-1:0] x_q       [DEPTH][NCH];
   logic signed [AW-1:0]   acc_q     [DEPTH][NCH];
   logic signed [AW-1:0]   x_src     [DEPTH][NCH];
   logic signed [AW-1:0]   acc_src   [DEPTH][NCH];
   logic signed [AW-1:0]   acc_nxt   [DEPTH][NCH];
   logic signed [AW-1:0]   scaled;
   logic [NCH*BITS-1:0]    out_nxt;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Per-lane, per-stage datapath: stage k applies weight term k to the
   // sign-extended sample travelling alongside the accumulator.
   for (genvar i = 0; i < NCH; i++) begin : g_lane
      localparam logic signed [BITS-1:0] W = WEIGHTS[i*BITS +: BITS];
      localparam longint WL   = longint'(W);
      localparam bit     CPLX = is_complex(WL);
      for (genvar k = 0; k < DEPTH; k++) begin : g_stage
         localparam longint T = term_val(WL, k);
         if (k == 0) begin : g_src
            assign x_src[k][i]   = {{BITS{data_in[i*BITS+BITS-1]}}, data_in[i*BITS +: BITS]};
            assign acc_src[k][i] = '0;
         end else begin : g_src
            assign x_src[k][i]   = {{BITS{x_q[k-1][i][BITS-1]}}, x_q[k-1][i]};
            assign acc_src[k][i] = acc_q[k-1][i];
         end
         if (CPLX && (k == 0)) begin : g_op
            localparam logic signed [AW-1:0] W_EXT = AW'(WL);
            assign acc_nxt[k][i] = x_src[k][i] * W_EXT;
         end else if (CPLX) begin : g_op
            assign acc_nxt[k][i] = acc_src[k][i];
         end else if (T > 0) begin : g_op
            localparam int SH = log2_exact(T);
            assign acc_nxt[k][i] = acc_src[k][i] + (x_src[k][i] <<< SH);
         end else if (T < 0) begin : g_op
            localparam int SH = log2_exact(-T);
            assign acc_nxt[k][i] = acc_src[k][i] - (x_src[k][i] <<< SH);
         end else begin : g_op
            assign acc_nxt[k][i] = acc_src[k][i];
         end
      end
   end

   // Rescale the final accumulator of every lane and clamp it into BITS.
   always_comb begin
      out_nxt = '0;
      scaled  = '0;
      for (int i = 0; i < NCH; i++) begin
`ifdef SHIFT_ADD_ROUND_EN
         scaled = (acc_q[DEPTH-1][i] + RND_HALF) >>> NFRAC;
`else
         scaled = acc_q[DEPTH-1][i] >>> NFRAC;
`endif
         if (scaled > SAT_MAX)
            out_nxt[i*BITS +: BITS] = SAT_MAX[BITS-1:0];
         else if (scaled < SAT_MIN)
            out_nxt[i*BITS +: BITS] = SAT_MIN[BITS-1:0];
         else
            out_nxt[i*BITS +: BITS] = scaled[BITS-1:0];
      end
   end

   // Whole pipeline, valid bits included, moves one place on adv and freezes
   // otherwise; reset empties every stage and the output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_vld[k] <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
               x_q[k][i]   <= '0;
               acc_q[k][i] <= '0;
            end
         end
         out_valid <= 1'b0;
         data_out  <= '0;
      end else if (adv) begin
         stage_vld[0] <= in_valid;
         for (int i = 0; i < NCH; i++) begin
            x_q[0][i] <= data_in[i*BITS +: BITS];
         end
         for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < NCH; i++) begin
               acc_q[k][i] <= acc_nxt[k][i];
            end
         end
         for (int k = 1; k < DEPTH; k++) begin
            stage_vld[k] <= stage_vld[k-1];
            for (int i = 0; i < NCH; i++) begin
               x_q[k][i] <= x_q[k-1][i];
            end
         end
         out_valid <= stage_vld[DEPTH-1];
         data_out  <= out_nxt;
      end
   end

endmodule

// File: tb/tb_shift_add_pipe.sv
// tb_shift_add_pipe: directed bench for shift_add_pipe with two instances
// (different weight sets) sharing stimulus and handshake. Expected vectors
// come from an exact-multiply reference model and are queued on accept,
// then compared in order whenever an output is taken.
module tb_shift_add_pipe;

   localparam int NCH   = 4;
   localparam int BITS  = 17;
   localparam int NFRAC = 8;
   localparam int DEPTH = 2;
   localparam int VW    = NCH * BITS;

   localparam logic [VW-1:0] WA = {17'sd0, 17'sd128, 17'sd512, 17'sd384};
   localparam logic [VW-1:0] WB = {-17'sd1000, 17'sd3, -17'sd384, 17'sd85};
   localparam int WA_L [NCH] = '{384, 512, 128, 0};
   localparam int WB_L [NCH] = '{85, -384, 3, -1000};

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          out_ready;
   logic [VW-1:0] data_in;
   logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [VW-1:0] data_out_a, data_out_b;

   int checks = 0;
   int errors = 0;
   int popped = 0;
   bit accepted = 0;
   bit held = 0;
   logic [VW-1:0]   held_a;
   logic [2*VW-1:0] exp_q [$];

   shift_add_pipe #(.NCH(NCH), .BITS(BITS), .NFRAC(NFRAC), .DEPTH(DEPTH), .WEIGHTS(WA)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
      .data_in(data_in), .out_valid(out_valid_a), .out_ready(out_ready), .data_out(data_out_a)
   );

   shift_add_pipe #(.NCH(NCH), .BITS(BITS), .NFRAC(NFRAC), .DEPTH(DEPTH), .WEIGHTS(WB)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
      .data_in(data_in), .out_valid(out_valid_b), .out_ready(out_ready), .data_out(data_out_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference lane: exact product, optional half-up rounding, shift, clamp.
   function automatic logic [BITS-1:0] model_lane(longint x, longint w);
      longint p = x * w;
      longint r;
`ifdef SHIFT_ADD_ROUND_EN
      p = p + (longint'(1) << (NFRAC - 1));
`endif
      r = p >>> NFRAC;
      if (r > (longint'(1) << (BITS-1)) - 1) r = (longint'(1) << (BITS-1)) - 1;
      else if (r < -(longint'(1) << (BITS-1))) r = -(longint'(1) << (BITS-1));
      return r[BITS-1:0];
   endfunction

   function automatic logic [VW-1:0] model_vec(logic [VW-1:0] din, bit use_b);
      logic [VW-1:0] v = '0;
      for (int l = 0; l < NCH; l++) begin
         longint x = longint'(signed'(din[l*BITS +: BITS]));
         longint w = use_b ? longint'(WB_L[l]) : longint'(WA_L[l]);
         v[l*BITS +: BITS] = model_lane(x, w);
      end
      return v;
   endfunction

   function automatic logic [VW-1:0] pack4(int l0, int l1, int l2, int l3);
      return {l3[BITS-1:0], l2[BITS-1:0], l1[BITS-1:0], l0[BITS-1:0]};
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [95:0] r = {$urandom(), $urandom(), $urandom()};
      return r[VW-1:0];
   endfunction

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: monitor at the falling edge (scoreboard pop on emit, push
   // on accept, hold checks while stalled), then step past the rising edge.
   task automatic tick();
      logic [2*VW-1:0] ev;
      @(negedge clk);
      if (held) begin
         check_output("hold_valid", 128'(out_valid_a), 128'(1'b1));
         check_output("hold_data", 128'(data_out_a), 128'(held_a));
      end
      if (out_valid_a && !out_ready)
         check_output("ready_stall", 128'(in_ready_a), 128'(1'b0));
      if (out_valid_a && out_ready) begin
         if (exp_q.size() == 0) begin
            check_output("spurious_out", 128'(out_valid_a), 128'(1'b0));
         end else begin
            ev = exp_q.pop_front();
            popped++;
            check_output("sb_a", 128'(data_out_a), 128'(ev[VW-1:0]));
            check_output("sb_b", 128'(data_out_b), 128'(ev[2*VW-1:VW]));
            check_output("valid_b", 128'(out_valid_b), 128'(1'b1));
         end
      end
      accepted = in_valid && in_ready_a;
      if (accepted) exp_q.push_back({model_vec(data_in, 1'b1), model_vec(data_in, 1'b0)});
      held   = out_valid_a && !out_ready;
      held_a = data_out_a;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 50 && (exp_q.size() != 0 || out_valid_a); n++) tick();
      check_output("drain_empty", 128'(exp_q.size()), 128'(0));
   endtask

   // Send one vector into an idle pipe and count cycles to out_valid.
   task automatic apply_stimulus(input logic [VW-1:0] vec, input string tag, input bit check_768);
      int lat;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      data_in   = vec;
      tick();
      in_valid = 1'b0;
      data_in  = rand_vec();
      lat = 1;
      while (!out_valid_a && lat < 20) begin
         tick();
         lat++;
      end
      check_output(tag, 128'(lat), 128'(DEPTH + 1));
      if (check_768) check_output("lane0_768", 128'(data_out_a[BITS-1:0]), 128'(17'd768));
      drain();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int sent;
      int start_pop;
      logic [VW-1:0] cur;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      data_in   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_valid", 128'(out_valid_a), 128'(1'b0));
      check_output("rst_data", 128'(data_out_a), 128'(0));
      check_output("rst_ready", 128'(in_ready_a), 128'(1'b1));
      reset = 1'b0;
      tick();

      $display("[TB] latency and weight 384");
      apply_stimulus(pack4(512, 100, 1, 1000), "latency_first", 1'b1);

      $display("[TB] saturation, rounding, complex and zero weights");
      in_valid  = 1'b1;
      out_ready = 1'b1;
      data_in = pack4(0, 65535, -1, 7);          tick();
      data_in = pack4(1, -65536, 1, 0);          tick();
      data_in = pack4(-1, 256, -1, 1000);        tick();
      data_in = pack4(256, 3, 100, -5);          tick();
      data_in = pack4(-65536, 65535, 65535, -65536); tick();
      drain();

      $display("[TB] stream with stalls");
      sent      = 0;
      start_pop = popped;
      cur       = rand_vec();
      for (int c = 0; c < 200 && (popped - start_pop) < 10; c++) begin
         in_valid  = (sent < 10);
         data_in   = in_valid ? cur : rand_vec();
         out_ready = (c >= 6 && c < 10) ? 1'b0 : (c % 2 == 0);
         tick();
         if (accepted) begin
            sent++;
            cur = rand_vec();
         end
      end
      check_output("stream_sent", 128'(sent), 128'(10));
      check_output("stream_recv", 128'(popped - start_pop), 128'(10));
      drain();

      $display("[TB] reset with vectors in flight");
      out_ready = 1'b0;
      in_valid  = 1'b1;
      data_in   = pack4(512, 10, 20, 30);
      tick();
      data_in   = pack4(-512, 40, 50, 60);
      tick();
      in_valid  = 1'b0;
      tick();
      check_output("pre_rst_valid", 128'(out_valid_a), 128'(1'b1));
      reset = 1'b1;
      #1;
      check_output("mid_rst_valid", 128'(out_valid_a), 128'(1'b0));
      check_output("mid_rst_data", 128'(data_out_a), 128'(0));
      check_output("mid_rst_valid_b", 128'(out_valid_b), 128'(1'b0));
      exp_q.delete();
      held = 1'b0;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      repeat (6) tick();
      check_output("no_stale", 128'(out_valid_a), 128'(1'b0));
      apply_stimulus(pack4(512, -7, 300, 9), "latency_after_rst", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
